// File: rtl/decoder_sweep_ctrl_if.sv
// Bus between the board-side inputs (switches, run button, stop) and the
// LED decoder sequencer. The master drives the raw inputs and watches the
// decoder select/enable and the status pulses.
interface decoder_sweep_ctrl_if;
  logic [3:0] sw;
  logic [1:0] mode;
  logic       run_btn;
  logic       stop;
  logic [3:0] dec_w;
  logic       dec_en;
  logic       running;
  logic       step_tick;
  logic       lap_done;

  modport master (
    output sw, mode, run_btn, stop,
    input  dec_w, dec_en, running, step_tick, lap_done
  );

  modport slave (
    input  sw, mode, run_btn, stop,
    output dec_w, dec_en, running, step_tick, lap_done
  );
endinterface

// File: rtl/decoder_sweep_ctrl.sv
// Sequencer for the 4-to-16 LED decoder. Produces the 4-bit select and the
// enable every cycle in one of four modes (manual, sweep up, sweep down,
// ping-pong). A debounced run button starts/pauses/resumes, stop returns to
// idle. Every output is a flop, so nothing combinational reaches the pins.
module decoder_sweep_ctrl #(
  parameter int unsigned STEP_DIV        = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  decoder_sweep_ctrl_if.slave bus
);

  localparam int PS_W = $clog2(STEP_DIV);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_MAN = 2'b00;
  localparam logic [1:0] MODE_UP  = 2'b01;
  localparam logic [1:0] MODE_DN  = 2'b10;
  localparam logic [1:0] MODE_PP  = 2'b11;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  typedef struct packed {
    logic [3:0] idx;
    logic       dir;
    logic       lap;
  } step_t;

  // Advance rule applied on a prescaler tick: returns new index, direction
  // and whether this step is a wrap / reversal.
  function automatic step_t step_rule(input logic [1:0] m,
                                      input logic [3:0] i,
                                      input logic       d);
    step_t s;
    s.idx = i;
    s.dir = d;
    s.lap = 1'b0;
    case (m)
      MODE_UP: begin
        s.idx = i + 4'd1;
        s.lap = (i == 4'd15);
      end
      MODE_DN: begin
        s.idx = i - 4'd1;
        s.lap = (i == 4'd0);
      end
      MODE_PP: begin
        if (d == DIR_UP) begin
          if (i == 4'd15) begin
            s.idx = 4'd14;
            s.dir = DIR_DN;
            s.lap = 1'b1;
          end else begin
            s.idx = i + 4'd1;
          end
        end else begin
          if (i == 4'd0) begin
            s.idx = 4'd1;
            s.dir = DIR_UP;
            s.lap = 1'b1;
          end else begin
            s.idx = i - 4'd1;
          end
        end
      end
      default: ;
    endcase
    return s;
  endfunction

  // Synchronizer stages (_p1 first flop, _p2 safe copy used by logic)
  logic [3:0] sw_p1, sw_p2;
  logic [1:0] mode_p1, mode_p2;
  logic       btn_p1, btn_p2;
  logic       stop_p1, stop_p2;

  // Debounce
  logic [DB_W-1:0] db_cnt;
  logic            btn_clean;
  logic            btn_clean_q;
  logic            press;

  // Sequencer state
  state_t          state, state_n;
  logic [3:0]      idx, idx_n;
  logic            dir, dir_n, dir_eff;
  logic [PS_W-1:0] ps_cnt, ps_n;
  logic [1:0]      mode_q;
  logic            pp_enter;
  logic            tick_n, lap_n;
  step_t           stp;

  // Output flops
  logic [3:0] dec_w_r;
  logic       dec_en_r;
  logic       running_r;
  logic       step_tick_r;
  logic       lap_done_r;

  // Two-flop synchronizers for every asynchronous board input
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_p1   <= '0;
      sw_p2   <= '0;
      mode_p1 <= '0;
      mode_p2 <= '0;
      btn_p1  <= 1'b0;
      btn_p2  <= 1'b0;
      stop_p1 <= 1'b0;
      stop_p2 <= 1'b0;
    end else begin
      sw_p1   <= bus.sw;
      sw_p2   <= sw_p1;
      mode_p1 <= bus.mode;
      mode_p2 <= mode_p1;
      btn_p1  <= bus.run_btn;
      btn_p2  <= btn_p1;
      stop_p1 <= bus.stop;
      stop_p2 <= stop_p1;
    end
  end

  // Run-button debounce: clean level flips only after a full stable run
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt      <= '0;
      btn_clean   <= 1'b0;
      btn_clean_q <= 1'b0;
    end else begin
      btn_clean_q <= btn_clean;
      if (btn_p2 != btn_clean) begin
        if (db_cnt == DB_LAST) begin
          btn_clean <= btn_p2;
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Only the rising edge of the clean level acts; release is ignored
  assign press    = btn_clean & ~btn_clean_q;
  assign pp_enter = (mode_p2 == MODE_PP) && (mode_q != MODE_PP);

  // Next-state, index, direction and prescaler decisions
  always_comb begin
    state_n = state;
    idx_n   = idx;
    dir_n   = dir;
    ps_n    = ps_cnt;
    tick_n  = 1'b0;
    lap_n   = 1'b0;
    dir_eff = dir;
    if (pp_enter) begin
      // Switching into ping-pong heads up, unless already at the top
      dir_eff = (idx == 4'd15) ? DIR_DN : DIR_UP;
    end
    stp = step_rule(mode_p2, idx, dir_eff);

    if (stop_p2) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            state_n = RUN;
            ps_n    = '0;
            dir_n   = DIR_UP;
            case (mode_p2)
              MODE_MAN: idx_n = sw_p2;
              MODE_DN:  idx_n = 4'd15;
              default:  idx_n = 4'd0;
            endcase
          end
        end
        RUN: begin
          dir_n = dir_eff;
          if (press) begin
            // Pause freezes the prescaler where it is so resume loses nothing
            state_n = HOLD;
          end else begin
            if (ps_cnt == PS_LAST) begin
              ps_n   = '0;
              tick_n = 1'b1;
              idx_n  = stp.idx;
              dir_n  = stp.dir;
              lap_n  = stp.lap;
            end else begin
              ps_n = ps_cnt + 1'b1;
            end
            if (mode_p2 == MODE_MAN) begin
              idx_n = sw_p2;
            end
          end
        end
        HOLD: begin
          dir_n = dir_eff;
          if (press) begin
            state_n = RUN;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State and registered outputs, all taken from the next-state values
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= 4'd0;
      dir         <= DIR_UP;
      ps_cnt      <= '0;
      mode_q      <= MODE_MAN;
      dec_w_r     <= 4'd0;
      dec_en_r    <= 1'b0;
      running_r   <= 1'b0;
      step_tick_r <= 1'b0;
      lap_done_r  <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      dir         <= dir_n;
      ps_cnt      <= ps_n;
      mode_q      <= mode_p2;
      dec_w_r     <= (state_n == IDLE) ? 4'd0 : idx_n;
      dec_en_r    <= (state_n != IDLE);
      running_r   <= (state_n == RUN);
      step_tick_r <= tick_n;
      lap_done_r  <= lap_n;
    end
  end

  assign bus.dec_w     = dec_w_r;
  assign bus.dec_en    = dec_en_r;
  assign bus.running   = running_r;
  assign bus.step_tick = step_tick_r;
  assign bus.lap_done  = lap_done_r;

endmodule

// File: tb/tb_decoder_sweep_ctrl.sv
// Directed bench for decoder_sweep_ctrl with STEP_DIV=3, DEBOUNCE_CYCLES=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_decoder_sweep_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  decoder_sweep_ctrl_if bus();

  decoder_sweep_ctrl #(
    .STEP_DIV       (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk4({tag, "_dec_w"},     bus.dec_w,     4'd0);
    chk1({tag, "_dec_en"},    bus.dec_en,    1'b0);
    chk1({tag, "_running"},   bus.running,   1'b0);
    chk1({tag, "_step_tick"}, bus.step_tick, 1'b0);
    chk1({tag, "_lap_done"},  bus.lap_done,  1'b0);
  endtask

  // Clean press: 2 sync + 4 debounce edges, then the edge that sees press
  task automatic press_go();
    bus.run_btn = 1'b1;
    cyc(7);
    bus.run_btn = 1'b0;
  endtask

  // Wait gap cycles; the last one must carry the tick with the given index
  task automatic expect_tick(input string tag, input logic [3:0] ei,
                             input logic el, input int gap);
    for (int c = 1; c <= gap; c++) begin
      cyc(1);
      if (c < gap) begin
        chk1({tag, "_quiet_tick"}, bus.step_tick, 1'b0);
        chk1({tag, "_quiet_lap"},  bus.lap_done,  1'b0);
      end
    end
    chk1({tag, "_tick"}, bus.step_tick, 1'b1);
    chk4({tag, "_idx"},  bus.dec_w,     ei);
    chk1({tag, "_lap"},  bus.lap_done,  el);
  endtask

  initial begin
    logic [3:0] e;
    int         v;

    reset       = 1'b1;
    bus.sw      = 4'd0;
    bus.mode    = 2'b00;
    bus.run_btn = 1'b0;
    bus.stop    = 1'b0;

    // 1. reset and idle
    cyc(2);
    chk_reset_vals("t1_rst");
    reset = 1'b0;
    cyc(4);
    chk_reset_vals("t1_idle");

    // 2. sweep up with press latency
    bus.mode = 2'b01;
    cyc(3);
    bus.run_btn = 1'b1;
    cyc(6);
    chk1("t2_not_yet_running", bus.running, 1'b0);
    cyc(1);
    chk1("t2_running", bus.running, 1'b1);
    chk1("t2_dec_en",  bus.dec_en,  1'b1);
    chk4("t2_start",   bus.dec_w,   4'd0);
    bus.run_btn = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      e = 4'(k);
      expect_tick($sformatf("t2_up%0d", k), e, (k == 16), 3);
    end

    // stop returns to idle after synchronizer delay
    bus.stop = 1'b1;
    cyc(2);
    chk1("t2_stop_still_run", bus.running, 1'b1);
    cyc(1);
    chk1("t2_stop_running", bus.running, 1'b0);
    chk1("t2_stop_dec_en",  bus.dec_en,  1'b0);
    chk4("t2_stop_dec_w",   bus.dec_w,   4'd0);
    bus.stop = 1'b0;

    // 3. ping-pong from 0
    bus.mode = 2'b11;
    cyc(6);
    press_go();
    chk1("t3_running", bus.running, 1'b1);
    chk4("t3_start",   bus.dec_w,   4'd0);
    for (int k = 1; k <= 31; k++) begin
      v = (k <= 15) ? k : ((k <= 30) ? (30 - k) : 1);
      e = 4'(v);
      expect_tick($sformatf("t3_pp%0d", k), e, (k == 16) || (k == 31), 3);
    end

    // 4. bounce gives no press; ticks keep going
    bus.run_btn = 1'b1; cyc(1);
    bus.run_btn = 1'b0; cyc(1);
    bus.run_btn = 1'b1; cyc(1);
    bus.run_btn = 1'b0;
    cyc(3);
    chk1("t4_bounce_running", bus.running,   1'b1);
    chk4("t4_bounce_idx",     bus.dec_w,     4'd3);
    chk1("t4_bounce_tick",    bus.step_tick, 1'b1);

    // pause with prescaler mid-count
    cyc(1);
    press_go();
    chk1("t4_hold_running", bus.running,   1'b0);
    chk1("t4_hold_dec_en",  bus.dec_en,    1'b1);
    chk4("t4_hold_idx",     bus.dec_w,     4'd5);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk4($sformatf("t4_frozen_idx%0d", i),  bus.dec_w,     4'd5);
      chk1($sformatf("t4_frozen_en%0d", i),   bus.dec_en,    1'b1);
      chk1($sformatf("t4_frozen_tick%0d", i), bus.step_tick, 1'b0);
      chk1($sformatf("t4_frozen_run%0d", i),  bus.running,   1'b0);
    end

    // resume: held count 1 means the next tick comes after 2 cycles
    press_go();
    chk1("t4_resume_running", bus.running,   1'b1);
    chk4("t4_resume_idx",     bus.dec_w,     4'd5);
    chk1("t4_resume_tick",    bus.step_tick, 1'b0);
    expect_tick("t4_resume", 4'd6, 1'b0, 2);

    // 5. manual mode
    bus.stop = 1'b1;
    cyc(3);
    chk1("t5_idle_dec_en", bus.dec_en, 1'b0);
    bus.stop = 1'b0;
    bus.mode = 2'b00;
    bus.sw   = 4'hA;
    cyc(6);
    press_go();
    chk1("t5_running", bus.running, 1'b1);
    chk4("t5_sw_a",    bus.dec_w,   4'hA);
    bus.sw = 4'h3;
    cyc(2);
    chk4("t5_sw_lag", bus.dec_w, 4'hA);
    cyc(1);
    chk4("t5_sw_3",   bus.dec_w, 4'h3);
    cyc(6);

    // stop coincident with press wins
    bus.run_btn = 1'b1;
    cyc(4);
    bus.stop = 1'b1;
    cyc(2);
    chk1("t5_pre_stop_running", bus.running, 1'b1);
    cyc(1);
    chk1("t5_stop_press_running", bus.running, 1'b0);
    chk1("t5_stop_press_dec_en",  bus.dec_en,  1'b0);
    chk4("t5_stop_press_dec_w",   bus.dec_w,   4'd0);
    bus.run_btn = 1'b0;
    bus.stop    = 1'b0;
    cyc(10);
    chk1("t5_after_release_running", bus.running, 1'b0);
    chk1("t5_after_release_dec_en",  bus.dec_en,  1'b0);

    // 6. reset mid-sweep with a tick pending
    bus.mode = 2'b01;
    cyc(3);
    press_go();
    chk4("t6_start", bus.dec_w, 4'd0);
    for (int k = 1; k <= 7; k++) begin
      e = 4'(k);
      expect_tick($sformatf("t6_up%0d", k), e, 1'b0, 3);
    end
    cyc(2);
    chk4("t6_pending_idx",  bus.dec_w,     4'd7);
    chk1("t6_pending_tick", bus.step_tick, 1'b0);
    reset = 1'b1;
    cyc(1);
    chk_reset_vals("t6_rst");
    reset = 1'b0;
    cyc(12);
    chk_reset_vals("t6_post_rst");
    press_go();
    chk1("t6_restart_running", bus.running, 1'b1);
    chk4("t6_restart_idx",     bus.dec_w,   4'd0);
    expect_tick("t6_restart", 4'd1, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
